// File: rtl/rf_mp_sb.sv
// rf_mp_sb: multi-port register file with a per-register busy scoreboard.
// Define RF_BYPASS_EN to enable the combinational write-through read bypass.
module rf_mp_sb #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int NR    = 4,
    parameter int NW    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NR*AW-1:0]   raddr,
    output logic [NR*DW-1:0]   rdata,
    output logic [NR-1:0]      rrdy,
    input  logic [NW-1:0]      we,
    input  logic [NW*AW-1:0]   waddr,
    input  logic [NW*DW-1:0]   wdata,
    input  logic               iss_en,
    input  logic [AW-1:0]      iss_addr,
    output logic [DEPTH-1:0]   busy,
    output logic [AW:0]        busy_cnt
);

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DW-1:0]    regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;

    // Later write ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NW; j++) begin
            if (we[j]) begin
                regs_d[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
            end
        end
        regs_d[0] = '0;
    end

    // Issue is applied after the write clears: a new producer supersedes.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NW; j++) begin
            if (we[j]) begin
                busy_d[waddr[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
        busy_cnt_d = '0;
        for (int r = 0; r < DEPTH; r++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;

    logic [NR-1:0]    byp_hit;
    logic [NR*DW-1:0] byp_val;

`ifdef RF_BYPASS_EN
    // Bypass is masked in reset so reads stay zero while rst_n is low.
    always_comb begin
        byp_hit = '0;
        byp_val = '0;
        for (int i = 0; i < NR; i++) begin
            for (int j = 0; j < NW; j++) begin
                if (rst_n && we[j] &&
                    waddr[j*AW +: AW] == raddr[i*AW +: AW] &&
                    raddr[i*AW +: AW] != '0) begin
                    byp_hit[i]           = 1'b1;
                    byp_val[i*DW +: DW]  = wdata[j*DW +: DW];
                end
            end
        end
    end
`else
    assign byp_hit = '0;
    assign byp_val = '0;
`endif

    always_comb begin
        rdata = '0;
        rrdy  = '0;
        for (int i = 0; i < NR; i++) begin
            rdata[i*DW +: DW] = regs_q[raddr[i*AW +: AW]];
            rrdy[i]           = ~busy_q[raddr[i*AW +: AW]];
            if (byp_hit[i]) begin
                rdata[i*DW +: DW] = byp_val[i*DW +: DW];
                rrdy[i] = !(iss_en && iss_addr == raddr[i*AW +: AW]);
            end
        end
    end

endmodule

// File: tb/tb_rf_mp_sb.sv
// tb_rf_mp_sb: scoreboard-driven bench for rf_mp_sb.
// Expected values are queued at drive time and popped when sampled.
module tb_rf_mp_sb;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int NW    = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR*AW-1:0]   raddr;
    logic [NR*DW-1:0]   rdata;
    logic [NR-1:0]      rrdy;
    logic [NW-1:0]      we;
    logic [NW*AW-1:0]   waddr;
    logic [NW*DW-1:0]   wdata;
    logic               iss_en;
    logic [AW-1:0]      iss_addr;
    logic [DEPTH-1:0]   busy;
    logic [AW:0]        busy_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    rf_mp_sb #(.DW(DW), .DEPTH(DEPTH), .NR(NR), .NW(NW)) dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata),
        .rrdy(rrdy), .we(we), .waddr(waddr), .wdata(wdata),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy(busy),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input int p, input int a);
        raddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        we[p] = 1'b1;
        waddr[p*AW +: AW] = AW'(a);
        wdata[p*DW +: DW] = d;
    endtask

    task automatic idle;
        we     = '0;
        iss_en = 1'b0;
    endtask

    task automatic issue(input int a);
        iss_en   = 1'b1;
        iss_addr = AW'(a);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle();
        raddr = '0; waddr = '0; wdata = '0; iss_addr = '0;
        #12;
        for (int a = 0; a < DEPTH; a++) begin
            for (int p = 0; p < NR; p++) begin
                set_r(p, (a + p) % DEPTH);
                exp_q.push_back(32'h0);
            end
            exp_q.push_back(32'hF);
            #1;
            for (int p = 0; p < NR; p++) begin
                e = exp_q.pop_front(); total++;
                if (rdata[p*DW +: DW] !== e) begin
                    bad++;
                    $display("FAIL reset_rdata a=%0d p=%0d got %h exp %h", a, p, rdata[p*DW +: DW], e);
                end
            end
            e = exp_q.pop_front(); total++;
            if (32'(rrdy) !== e) begin
                bad++;
                $display("FAIL reset_rrdy a=%0d got %h exp %h", a, rrdy, e);
            end
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); total++;
        if (busy !== e) begin
            bad++; $display("FAIL reset_busy got %h exp %h", busy, e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(busy_cnt) !== e) begin
            bad++; $display("FAIL reset_cnt got %0d exp %0d", busy_cnt, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read;
        @(negedge clk);
        wr(0, 5, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        idle();
        set_r(0, 5);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h1);
        #1;
        e = exp_q.pop_front(); total++;
        if (rdata[0 +: DW] !== e) begin
            bad++; $display("FAIL wr_rd_data got %h exp %h", rdata[0 +: DW], e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(rrdy[0]) !== e) begin
            bad++; $display("FAIL wr_rd_rdy got %0d exp %0d", rrdy[0], e);
        end
        @(negedge clk);
        wr(0, 0, 32'h12345678);
        tick();
        @(negedge clk);
        idle();
        set_r(1, 0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        #1;
        e = exp_q.pop_front(); total++;
        if (rdata[DW +: DW] !== e) begin
            bad++; $display("FAIL r0_data got %h exp %h", rdata[DW +: DW], e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(rrdy[1]) !== e) begin
            bad++; $display("FAIL r0_rdy got %0d exp %0d", rrdy[1], e);
        end
    endtask

    task automatic test_collision;
        @(negedge clk);
        wr(0, 9, 32'h11111111);
        wr(1, 9, 32'h22222222);
        tick();
        @(negedge clk);
        idle();
        set_r(2, 9);
        exp_q.push_back(32'h22222222);
        #1;
        e = exp_q.pop_front(); total++;
        if (rdata[2*DW +: DW] !== e) begin
            bad++; $display("FAIL collision got %h exp %h", rdata[2*DW +: DW], e);
        end
    endtask

    task automatic test_scoreboard;
        @(negedge clk);
        issue(7);
        set_r(3, 7);
        tick();
        exp_q.push_back(32'h80);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); total++;
        if (busy !== e) begin
            bad++; $display("FAIL sb_busy_set got %h exp %h", busy, e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(busy_cnt) !== e) begin
            bad++; $display("FAIL sb_cnt_set got %0d exp %0d", busy_cnt, e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(rrdy[3]) !== e) begin
            bad++; $display("FAIL sb_rrdy_busy got %0d exp %0d", rrdy[3], e);
        end
        @(negedge clk);
        idle();
        tick();
        @(negedge clk);
        wr(0, 7, 32'hA5A5A5A5);
        tick();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hA5A5A5A5);
        exp_q.push_back(32'h1);
        e = exp_q.pop_front(); total++;
        if (busy !== e) begin
            bad++; $display("FAIL sb_busy_clr got %h exp %h", busy, e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(busy_cnt) !== e) begin
            bad++; $display("FAIL sb_cnt_clr got %0d exp %0d", busy_cnt, e);
        end
        e = exp_q.pop_front(); total++;
        if (rdata[3*DW +: DW] !== e) begin
            bad++; $display("FAIL sb_data got %h exp %h", rdata[3*DW +: DW], e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(rrdy[3]) !== e) begin
            bad++; $display("FAIL sb_rrdy_clr got %0d exp %0d", rrdy[3], e);
        end
        @(negedge clk);
        idle();
        issue(7);
        wr(1, 7, 32'h5A5A5A5A);
        tick();
        exp_q.push_back(32'h80);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h5A5A5A5A);
        e = exp_q.pop_front(); total++;
        if (busy !== e) begin
            bad++; $display("FAIL sb_set_wins got %h exp %h", busy, e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(busy_cnt) !== e) begin
            bad++; $display("FAIL sb_set_wins_cnt got %0d exp %0d", busy_cnt, e);
        end
        e = exp_q.pop_front(); total++;
        if (rdata[3*DW +: DW] !== e) begin
            bad++; $display("FAIL sb_set_wins_data got %h exp %h", rdata[3*DW +: DW], e);
        end
        @(negedge clk);
        idle();
        issue(0);
        wr(0, 7, 32'h0000_0007);
        tick();
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); total++;
        if (busy !== e) begin
            bad++; $display("FAIL sb_r0_issue got %h exp %h", busy, e);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_bypass;
        @(negedge clk);
        wr(0, 3, 32'h33333333);
        tick();
        @(negedge clk);
        idle();
        issue(3);
        tick();
        @(negedge clk);
        idle();
        wr(1, 3, 32'hCAFEF00D);
        set_r(2, 3);
`ifdef RF_BYPASS_EN
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(32'h1);
`else
        exp_q.push_back(32'h33333333);
        exp_q.push_back(32'h0);
`endif
        #1;
        e = exp_q.pop_front(); total++;
        if (rdata[2*DW +: DW] !== e) begin
            bad++; $display("FAIL byp_data got %h exp %h", rdata[2*DW +: DW], e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(rrdy[2]) !== e) begin
            bad++; $display("FAIL byp_rrdy got %0d exp %0d", rrdy[2], e);
        end
        tick();
        @(negedge clk);
        idle();
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(32'h1);
        #1;
        e = exp_q.pop_front(); total++;
        if (rdata[2*DW +: DW] !== e) begin
            bad++; $display("FAIL byp_next_data got %h exp %h", rdata[2*DW +: DW], e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(rrdy[2]) !== e) begin
            bad++; $display("FAIL byp_next_rrdy got %0d exp %0d", rrdy[2], e);
        end
        @(negedge clk);
        issue(3);
        wr(1, 3, 32'h44444444);
`ifdef RF_BYPASS_EN
        exp_q.push_back(32'h44444444);
        exp_q.push_back(32'h0);
`else
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(32'h1);
`endif
        #1;
        e = exp_q.pop_front(); total++;
        if (rdata[2*DW +: DW] !== e) begin
            bad++; $display("FAIL byp_iss_data got %h exp %h", rdata[2*DW +: DW], e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(rrdy[2]) !== e) begin
            bad++; $display("FAIL byp_iss_rrdy got %0d exp %0d", rrdy[2], e);
        end
        tick();
        @(negedge clk);
        idle();
        exp_q.push_back(32'h44444444);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); total++;
        if (rdata[2*DW +: DW] !== e) begin
            bad++; $display("FAIL byp_after_data got %h exp %h", rdata[2*DW +: DW], e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(rrdy[2]) !== e) begin
            bad++; $display("FAIL byp_after_rrdy got %0d exp %0d", rrdy[2], e);
        end
        @(negedge clk);
        wr(0, 3, 32'h0);
        tick();
        @(negedge clk);
        idle();
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        issue(10);
        tick();
        @(negedge clk);
        issue(11);
        tick();
        @(negedge clk);
        issue(12);
        wr(0, 12, 32'h77);
        tick();
        @(negedge clk);
        idle();
        set_r(0, 12);
        set_r(1, 5);
        exp_q.push_back(32'h3);
        exp_q.push_back(32'h1C00);
        exp_q.push_back(32'h77);
        #1;
        e = exp_q.pop_front(); total++;
        if (32'(busy_cnt) !== e) begin
            bad++; $display("FAIL ar_pre_cnt got %0d exp %0d", busy_cnt, e);
        end
        e = exp_q.pop_front(); total++;
        if (busy !== e) begin
            bad++; $display("FAIL ar_pre_busy got %h exp %h", busy, e);
        end
        e = exp_q.pop_front(); total++;
        if (rdata[0 +: DW] !== e) begin
            bad++; $display("FAIL ar_pre_data got %h exp %h", rdata[0 +: DW], e);
        end
        @(negedge clk);
        wr(0, 12, 32'h99);
        #2;
        rst_n = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); total++;
        if (busy !== e) begin
            bad++; $display("FAIL ar_busy got %h exp %h", busy, e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(busy_cnt) !== e) begin
            bad++; $display("FAIL ar_cnt got %0d exp %0d", busy_cnt, e);
        end
        e = exp_q.pop_front(); total++;
        if (rdata[0 +: DW] !== e) begin
            bad++; $display("FAIL ar_data got %h exp %h", rdata[0 +: DW], e);
        end
        e = exp_q.pop_front(); total++;
        if (32'(rrdy[0]) !== e) begin
            bad++; $display("FAIL ar_rrdy got %0d exp %0d", rrdy[0], e);
        end
        e = exp_q.pop_front(); total++;
        if (rdata[DW +: DW] !== e) begin
            bad++; $display("FAIL ar_r5 got %h exp %h", rdata[DW +: DW], e);
        end
        tick();
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); total++;
        if (rdata[0 +: DW] !== e) begin
            bad++; $display("FAIL ar_write_lost got %h exp %h", rdata[0 +: DW], e);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        tick();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); total++;
        if (rdata[0 +: DW] !== e) begin
            bad++; $display("FAIL ar_post_data got %h exp %h", rdata[0 +: DW], e);
        end
        e = exp_q.pop_front(); total++;
        if (busy !== e) begin
            bad++; $display("FAIL ar_post_busy got %h exp %h", busy, e);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_scoreboard();
        test_bypass();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
